// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl: drives one 3-bit ripple-adder slice (full_add_3b) a chunk
// per clock, least-significant chunk first, and assembles a 3*WORDS-bit sum.
// The carry out of each chunk feeds the next chunk's carry in.
// Optional build macro: SERIAL_SUB_EN adds a 'sub' input. When sub=1 the slice
// sees ~B and an initial carry of 1, so the result is A - B.
//
// state | meaning
// IDLE  | waiting for start; adder inputs held at 0
// RUN   | one chunk per clock, chunk index r_idx
// DONE  | one-cycle done pulse; a start here is accepted as in IDLE
module add_serial_ctrl #(
  parameter int WORDS = 4,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3*WORDS-1:0] op_a,
  input  logic [3*WORDS-1:0] op_b,
  input  logic               cin_in,
`ifdef SERIAL_SUB_EN
  input  logic               sub,
`endif
  output logic [2:0]         add_a,
  output logic [2:0]         add_b,
  output logic               add_cin,
  input  logic [2:0]         add_sum,
  input  logic               add_cout,
  output logic               busy,
  output logic               done,
  output logic [3*WORDS-1:0] result,
  output logic               carry_out
);

  localparam int W = 3 * WORDS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic             r_carry;
  logic [W-1:0]     r_result;
  logic             r_carry_out;
`ifdef SERIAL_SUB_EN
  logic             r_sub;
`endif

  logic             w_accept;
  logic             w_last;
  logic             w_run;
  logic             w_init_carry;
  logic [2:0]       w_chunk_a;
  logic [2:0]       w_chunk_b;
  logic [2:0]       w_chunk_b_eff;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));
  assign w_run    = (r_state == S_RUN);

`ifdef SERIAL_SUB_EN
  // Subtraction forces the initial carry to 1 (two's complement of B).
  assign w_init_carry  = sub ? 1'b1 : cin_in;
  assign w_chunk_b_eff = r_sub ? ~w_chunk_b : w_chunk_b;
`else
  assign w_init_carry  = cin_in;
  assign w_chunk_b_eff = w_chunk_b;
`endif

  // Select the current operand chunks from the latched copies.
  always_comb begin
    w_chunk_a = 3'b000;
    w_chunk_b = 3'b000;
    for (int i = 0; i < WORDS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_chunk_a = r_op_a[3*i +: 3];
        w_chunk_b = r_op_b[3*i +: 3];
      end
    end
  end

  assign add_a     = w_run ? w_chunk_a     : 3'b000;
  assign add_b     = w_run ? w_chunk_b_eff : 3'b000;
  assign add_cin   = w_run ? r_carry       : 1'b0;
  assign busy      = w_run;
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;

  // Sequencer: IDLE -> RUN for WORDS cycles -> DONE for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (w_last) r_state <= S_DONE;
        S_DONE:  r_state <= start ? S_RUN : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand latch on accept, then per-chunk sum capture and carry chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
`ifdef SERIAL_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_idx       <= '0;
      r_op_a      <= op_a;
      r_op_b      <= op_b;
      r_carry     <= w_init_carry;
      r_result    <= '0;
      r_carry_out <= 1'b0;
`ifdef SERIAL_SUB_EN
      r_sub       <= sub;
`endif
    end else if (w_run) begin
      for (int i = 0; i < WORDS; i++) begin
        if (r_idx == IDX_W'(i)) r_result[3*i +: 3] <= add_sum;
      end
      r_carry <= add_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) r_carry_out <= add_cout;
    end
  end

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Scoreboard bench for add_serial_ctrl (WORDS=4 main instance, WORDS=1 corner).
module tb_add_serial_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 3 * WORDS;
  localparam int WMASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin_in = 1'b0;
  logic         sub = 1'b0;
  logic [2:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout, busy, done, carry_out;
  logic [W-1:0] result;

  logic         start1 = 1'b0;
  logic [2:0]   op_a1 = '0, op_b1 = '0;
  logic [2:0]   add_a1, add_b1, add_sum1, result1;
  logic         add_cin1, add_cout1, busy1, done1, carry_out1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int free_cyc = 0;

  typedef struct {
    int a;
    int bp;
    int ci;
    int c0;
  } op_t;
  op_t q[$];

  always #5 clk = ~clk;

  // Behavioural full_add_3b slices.
  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {3'b000, add_cin1};

  add_serial_ctrl #(.WORDS(WORDS), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cin_in(cin_in),
`ifdef SERIAL_SUB_EN
    .sub(sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .add_cout(add_cout), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out)
  );

  add_serial_ctrl #(.WORDS(1), .IDX_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .cin_in(1'b0),
`ifdef SERIAL_SUB_EN
    .sub(1'b0),
`endif
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(add_sum1),
    .add_cout(add_cout1), .busy(busy1), .done(done1), .result(result1),
    .carry_out(carry_out1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted start occupies the block for WORDS+1 edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      free_cyc = 0;
    end else begin
      cyc++;
      if (start && cyc >= free_cyc) begin
        op_t e;
        e.a  = int'(op_a);
        e.bp = int'(op_b);
        e.ci = int'(cin_in);
`ifdef SERIAL_SUB_EN
        if (sub) begin
          e.bp = (~int'(op_b)) & WMASK;
          e.ci = 1;
        end
`endif
        e.c0 = cyc;
        q.push_back(e);
        free_cyc = cyc + WORDS + 1;
      end
    end
  end

  // Monitor: compares status, adder drive and final result against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      int k, sh, m, s, ea, eb, ec, eb_busy, e_done;
      ea = 0; eb = 0; ec = 0; eb_busy = 0; e_done = 0; k = 0;
      if (q.size() > 0) begin
        k = cyc - q[0].c0;
        if (k < WORDS) begin
          eb_busy = 1;
          sh = 3 * k;
          m  = (1 << sh) - 1;
          ea = (q[0].a >> sh) & 7;
          eb = (q[0].bp >> sh) & 7;
          ec = ((q[0].a & m) + (q[0].bp & m) + q[0].ci) >> sh;
        end else if (k == WORDS) begin
          e_done = 1;
        end
      end
      chk("busy", int'(busy), eb_busy);
      chk("done", int'(done), e_done);
      chk("add_a", int'(add_a), ea);
      chk("add_b", int'(add_b), eb);
      chk("add_cin", int'(add_cin), ec);
      if (e_done) begin
        s = q[0].a + q[0].bp + q[0].ci;
        chk("result", int'(result), s & WMASK);
        chk("carry_out", int'(carry_out), (s >> W) & 1);
        void'(q.pop_front());
      end else if (q.size() > 0 && k > WORDS) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no done, expected done at cycle %0d", q[0].c0 + WORDS);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input int a, input int b, input int ci, input int sb);
    @(negedge clk);
    start  = 1'b1;
    op_a   = W'(a);
    op_b   = W'(b);
    cin_in = ci[0];
    sub    = sb[0];
    @(negedge clk);
    start  = 1'b0;
    op_a   = W'($urandom);
    op_b   = W'($urandom);
    cin_in = 1'b0;
    sub    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got %0d pending ops, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_carry_out", int'(carry_out), 0);
    chk("rst_add_a", int'(add_a), 0);
    rst_n = 1'b1;

    issue('h123, 'h456, 0, 0); wait_idle();
    issue('hFFF, 'h001, 0, 0); wait_idle();

    // Start held through RUN: only the DONE-cycle start is accepted.
    @(negedge clk);
    start = 1'b1; op_a = '0; op_b = '0; cin_in = 1'b1;
    @(negedge clk);
    op_a = 'h111; op_b = 'h222; cin_in = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-RUN discards the operation.
    issue('h7FF, 'h001, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_carry_out", int'(carry_out), 0);
    chk("arst_add_b", int'(add_b), 0);
    chk("arst_add_cin", int'(add_cin), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue('h010, 'h020, 0, 0); wait_idle();
    chk("post_rst_result", int'(result), 'h030);

`ifdef SERIAL_SUB_EN
    issue('h100, 'h001, 0, 1); wait_idle();
    issue('h001, 'h002, 1, 1); wait_idle();
    chk("sub_result", int'(result), 'hFFF);
`endif

    // WORDS=1 corner: 5 + 3 wraps to 0 with carry out.
    @(negedge clk);
    start1 = 1'b1; op_a1 = 3'd5; op_b1 = 3'd3;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", int'(busy1), 1);
    chk("w1_add_a", int'(add_a1), 5);
    @(negedge clk);
    chk("w1_done", int'(done1), 1);
    chk("w1_busy_done", int'(busy1), 0);
    chk("w1_result", int'(result1), 0);
    chk("w1_carry_out", int'(carry_out1), 1);
    @(negedge clk);
    chk("w1_done_pulse", int'(done1), 0);
    chk("w1_result_hold", int'(result1), 0);

    // Random traffic: starts at random times, operands change every cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      op_a   = W'($urandom);
      op_b   = W'($urandom);
      cin_in = 1'($urandom);
`ifdef SERIAL_SUB_EN
      sub    = 1'($urandom);
`endif
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_serial_ctrl.md
Name: add_serial_ctrl

Overview:
Sequencing stage wrapped around the 3-bit ripple adder (full_add_3b).
- Upstream side: slices wide operands into 3-bit chunks and drives the adder's a/b/cin one chunk per cycle, least-significant chunk first.
- Downstream side: captures each chunk's sum and the top carry, chains that carry into the next chunk, and assembles the wide result.
- Gives a 3*WORDS-bit adder built from one 3-bit slice, at one chunk per clock.

Parameters:
WORDS, 4, number of 3-bit chunks; operand/result width W = 3*WORDS; legal range 1..16
IDX_W, 4, width of internal chunk index; must satisfy 2^IDX_W >= WORDS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new addition; sampled on rising edge
op_a  in  W  operand A; sampled only when start is accepted
op_b  in  W  operand B; sampled only when start is accepted
cin_in  in  1  initial carry into chunk 0; sampled with operands
add_a  out  3  chunk of A to adder input a
add_b  out  3  chunk of B to adder input b
add_cin  out  1  carry to adder input cin
add_sum  in  3  adder sum output, combinational from add_a/add_b/add_cin
add_cout  in  1  adder top carry, i.e. its cout[2]
busy  out  1  high while a computation is in progress
done  out  1  one-cycle pulse; result and carry_out valid from this cycle
result  out  W  assembled sum, held until next accepted start
carry_out  out  1  final carry out of chunk WORDS-1

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous, active-low. Reset is applied immediately on assertion and released on a clock edge.
- Reset values: state=IDLE, busy=0, done=0, result=0, carry_out=0, add_a=0, add_b=0, add_cin=0, idx=0, internal operand and carry registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → latch op_a, op_b, cin_in (cin_in goes to the carry reg); idx<=0; clear result to 0; go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - add_a = opA_reg[3*idx+2 : 3*idx]; add_b = same slice of opB_reg; add_cin = carry reg. These are registered-source combinational slices.
  - Each edge: result[3*idx+2 : 3*idx] <= add_sum; carry reg <= add_cout; idx <= idx+1.
  - After the edge that captures idx==WORDS-1: carry_out <= add_cout; go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0; next edge goes to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, enabling back-to-back operations.
- busy=1 only in RUN.
- Outside RUN, add_a/add_b/add_cin are driven 0.
- Latency: start sampled at edge E0 → RUN spans WORDS cycles → done high in the cycle after edge E0+WORDS. Throughput is one operation per WORDS+1 cycles.
- start while in RUN is ignored. No queuing; operands are not resampled.
- Operand inputs may change freely after acceptance; internal copies are used.
- WORDS=1: RUN lasts one cycle; no special casing.
- Wrap-around: addition is modulo 2^W; the overflow bit appears only on carry_out.
- Reset during RUN or DONE: immediate return to reset values. The partial result is discarded and no done pulse is produced.
- result and carry_out are stable from done until the next accepted start. They are cleared on acceptance and partially updated during RUN.

Optional Feature:
SERIAL_SUB_EN
- Defined:
  - Extra input port sub (1 bit), sampled with operands.
  - When sub=1: add_b presents the bitwise inverse of the opB chunk, and the initial carry is forced to 1 (cin_in ignored). result = op_a - op_b mod 2^W; carry_out=1 means no borrow.
  - When sub=0: behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Test Plan:
- WORDS=4, op_a=0x123, op_b=0x456, cin_in=0, pulse start → busy high 4 cycles; done in cycle 5 after start edge; result=0x579, carry_out=0.
- op_a=0xFFF, op_b=0x001, cin_in=0 → result=0x000, carry_out=1. Check add_cin=1 on chunks 1..3.
- op_a=0x000, op_b=0x000, cin_in=1 → result=0x001, carry_out=0. Hold start high through RUN → second op accepted only in the DONE cycle, and its done arrives 5 cycles later.
- Start op 0x7FF+0x001, deassert rst_n at RUN cycle 2 (asynchronously, mid-cycle) → outputs go to 0 immediately; no done. After release, op 0x010+0x020 → result=0x030.
- WORDS=1: op_a=0x5, op_b=0x3 → done 2 cycles after start edge; result=0x0, carry_out=1.
- SERIAL_SUB_EN: sub=1, op_a=0x100, op_b=0x001 → result=0x0FF, carry_out=1. With op_a=0x001, op_b=0x002 → result=0xFFF, carry_out=0.
